// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the machine-mode CSR controller:
//   - CSR address constants
//   - access opcode enum (read-only / read-write / set / clear)
//   - controller FSM state enum
//   - misa field constants and the read-only address decode helper
// -----------------------------------------------------------------------------
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        OP_RO = 2'b00,
        OP_RW = 2'b01,
        OP_RS = 2'b10,
        OP_RC = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } csr_state_e;

    // misa: MXL field in the top two bits, extension bitmap in the low 26 bits.
    localparam logic [1:0]  MISA_MXL = 2'b10;
    localparam logic [25:0] MISA_EXT = 26'h000_0100;   // 'I' only

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // The whole 0xC00-0xFFF quadrant is read-only by encoding; misa is
    // additionally read-only in this implementation.
    function automatic logic is_read_only(input logic [11:0] addr);
        return (addr[11:10] == 2'b11) || (addr == CSR_MISA);
    endfunction

endpackage

// File: rtl/csr_counter.sv
// -----------------------------------------------------------------------------
// csr_counter
// N-bit free-running counter with increment enable and a load port that takes
// priority over the increment (a software write wins over counting).
// Ports:
//   clk, reset        clock, asynchronous active-high reset (clears to 0)
//   inc               increment by one this cycle (wraps 2^N-1 -> 0)
//   load, load_val    load load_val this cycle instead of incrementing
//   count             current counter value
// -----------------------------------------------------------------------------
module csr_counter
    import csr_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc) begin
            count_d = count_q + N'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/csr_ctrl.sv
// -----------------------------------------------------------------------------
// csr_ctrl
// Machine-mode CSR access controller. One access at a time walks the
// IDLE -> READ -> WRITE -> RESP sequence: capture request, read old value and
// decode legality, commit the new value, then a one-cycle response strobe.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   req_valid / req_ready         request handshake (ready only in IDLE)
//   req_addr, req_op, req_nowrite CSR address, op (RO/RW/RS/RC), write suppress
//   req_wdata                     write value or set/clear mask
//   instret                       instruction-retired pulse for minstret
//   rsp_valid                     one-cycle response strobe
//   rsp_rdata, rsp_illegal        value before the access / access fault
// -----------------------------------------------------------------------------
module csr_ctrl
    import csr_pkg::*;
#(
    parameter int          N      = 64,
    parameter int unsigned HARTID = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [11:0]  req_addr,
    input  logic [1:0]   req_op,
    input  logic         req_nowrite,
    input  logic [N-1:0] req_wdata,
    input  logic         instret,
    output logic         rsp_valid,
    output logic [N-1:0] rsp_rdata,
    output logic         rsp_illegal
);

    localparam logic [N-1:0] MISA_VAL = {MISA_MXL, {(N-28){1'b0}}, MISA_EXT};

    csr_state_e   state_q, state_d;
    logic [11:0]  addr_q, addr_d;
    csr_op_e      op_q, op_d;
    logic         nowrite_q, nowrite_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] old_q, old_d;
    logic         illegal_q, illegal_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [N-1:0] rsp_rdata_q, rsp_rdata_d;
    logic         rsp_illegal_q, rsp_illegal_d;

    logic         mie_q, mpie_q;
    logic [N-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [N-1:0] mcycle, minstret;

    logic         handshake;
    logic [N-1:0] mstatus_val;
    logic [N-1:0] rd_val;
    logic         rd_hit;
    logic         write_attempt;
    logic         rd_illegal;
    logic [N-1:0] new_val;
    logic         commit;

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign handshake = req_valid && req_ready;

    // Read mux and legality decode work on the captured request only.
    always_comb begin
        mstatus_val = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[MSTATUS_MPIE] = mpie_q;
        mstatus_val[MSTATUS_MIE] = mie_q;

        rd_hit = 1'b1;
        rd_val = '0;
        case (addr_q)
            CSR_MSTATUS:  rd_val = mstatus_val;
            CSR_MISA:     rd_val = MISA_VAL;
            CSR_MTVEC:    rd_val = mtvec_q;
            CSR_MSCRATCH: rd_val = mscratch_q;
            CSR_MEPC:     rd_val = mepc_q;
            CSR_MCAUSE:   rd_val = mcause_q;
            CSR_MCYCLE:   rd_val = mcycle;
            CSR_MINSTRET: rd_val = minstret;
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rd_val = '0;
            CSR_MHARTID:  rd_val = N'(HARTID);
            default:      rd_hit = 1'b0;
        endcase

        // RW always counts as a write attempt; RS/RC only when rs1 != x0.
        write_attempt = (op_q == OP_RW) ||
                        (((op_q == OP_RS) || (op_q == OP_RC)) && !nowrite_q);
        rd_illegal = !rd_hit || (write_attempt && is_read_only(addr_q));
    end

    always_comb begin
        case (op_q)
            OP_RW:   new_val = wdata_q;
            OP_RS:   new_val = old_q | wdata_q;
            OP_RC:   new_val = old_q & ~wdata_q;
            default: new_val = old_q;
        endcase
        commit = (state_q == ST_WRITE) && (op_q != OP_RO) && !nowrite_q && !illegal_q;
    end

    // Controller FSM: next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        op_d          = op_q;
        nowrite_d     = nowrite_q;
        wdata_d       = wdata_q;
        old_d         = old_q;
        illegal_d     = illegal_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    addr_d    = req_addr;
                    op_d      = csr_op_e'(req_op);
                    nowrite_d = req_nowrite;
                    wdata_d   = req_wdata;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                // Illegal accesses report zero rather than the CSR contents.
                old_d     = rd_illegal ? '0 : rd_val;
                illegal_d = rd_illegal;
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = old_q;
                rsp_illegal_d = illegal_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            op_q          <= OP_RO;
            nowrite_q     <= 1'b0;
            wdata_q       <= '0;
            old_q         <= '0;
            illegal_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            op_q          <= op_d;
            nowrite_q     <= nowrite_d;
            wdata_q       <= wdata_d;
            old_q         <= old_d;
            illegal_q     <= illegal_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_illegal = rsp_illegal_q;

    // Writable storage CSRs; WARL masking applied on the way in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (commit) begin
            case (addr_q)
                CSR_MSTATUS: begin
                    mie_q  <= new_val[MSTATUS_MIE];
                    mpie_q <= new_val[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_q    <= {new_val[N-1:2], 2'b00};
                CSR_MSCRATCH: mscratch_q <= new_val;
                CSR_MEPC:     mepc_q     <= {new_val[N-1:2], 2'b00};
                CSR_MCAUSE:   mcause_q   <= new_val;
                default: ;
            endcase
        end
    end

    csr_counter #(.N(N)) u_mcycle (
        .clk      (clk),
        .reset    (reset),
        .inc      (1'b1),
        .load     (commit && (addr_q == CSR_MCYCLE)),
        .load_val (new_val),
        .count    (mcycle)
    );

    csr_counter #(.N(N)) u_minstret (
        .clk      (clk),
        .reset    (reset),
        .inc      (instret),
        .load     (commit && (addr_q == CSR_MINSTRET)),
        .load_val (new_val),
        .count    (minstret)
    );

endmodule

// File: tb/tb_csr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_csr_ctrl
// Directed plus randomized accesses to csr_ctrl, checked against a behavioural
// CSR model. Counters are modelled as "value written at edge w" plus elapsed
// edges (mcycle) or retired-pulse count (minstret) since then.
// -----------------------------------------------------------------------------
module tb_csr_ctrl;

    localparam int N    = 64;
    localparam int HART = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [11:0]  req_addr;
    logic [1:0]   req_op;
    logic         req_nowrite;
    logic [N-1:0] req_wdata;
    logic         instret;
    logic         rsp_valid;
    logic [N-1:0] rsp_rdata;
    logic         rsp_illegal;

    int tests = 0;
    int fails = 0;

    // Edge counter and cumulative instret pulses sampled at each edge.
    int cyc = 0;
    int icum [0:19999];

    // Model state
    logic        m_mie, m_mpie;
    logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] mc_v, mi_v;
    int          mc_w, mi_w;

    csr_ctrl #(.N(N), .HARTID(HART)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_op      (req_op),
        .req_nowrite (req_nowrite),
        .req_wdata   (req_wdata),
        .instret     (instret),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_illegal (rsp_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        icum[cyc + 1] <= icum[cyc] + (instret ? 1 : 0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        instret = ($urandom_range(0, 1) == 1);
    endtask

    task automatic model_reset();
        m_mie = 1'b0; m_mpie = 1'b0;
        m_mtvec = '0; m_mscratch = '0; m_mepc = '0; m_mcause = '0;
        mc_v = '0; mc_w = cyc;
        mi_v = '0; mi_w = cyc;
    endtask

    // Value of CSR a as seen just before edge k+1 (the READ edge of an
    // access whose handshake was at edge k).
    task automatic model_read(input logic [11:0] a, input int k,
                              output logic hit, output logic [63:0] v);
        hit = 1'b1;
        v = '0;
        case (a)
            12'h300: v = 64'h1800 | (64'(m_mpie) << 7) | (64'(m_mie) << 3);
            12'h301: v = 64'h8000_0000_0000_0100;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'hB00: v = mc_v + 64'(k - mc_w);
            12'hB02: v = mi_v + 64'(icum[k] - icum[mi_w]);
            12'hF11, 12'hF12, 12'hF13: v = '0;
            12'hF14: v = 64'(HART);
            default: hit = 1'b0;
        endcase
    endtask

    task automatic model_write(input logic [11:0] a, input logic [1:0] op,
                               input logic [63:0] old, input logic [63:0] wd, input int w);
        logic [63:0] nv;
        case (op)
            2'b01:   nv = wd;
            2'b10:   nv = old | wd;
            default: nv = old & ~wd;
        endcase
        case (a)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h305: m_mtvec    = nv & ~64'h3;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc     = nv & ~64'h3;
            12'h342: m_mcause   = nv;
            12'hB00: begin mc_v = nv; mc_w = w; end
            12'hB02: begin mi_v = nv; mi_w = w; end
            default: ;
        endcase
    endtask

    // One complete access; entered and left at a negedge with the DUT idle.
    task automatic access(input logic [11:0] a, input logic [1:0] op, input logic nw,
                          input logic [63:0] wd, output logic [63:0] rd, output logic il);
        int          k;
        logic        hit, attempt, exp_il;
        logic [63:0] old;
        check("ready_idle", req_ready, 1'b1);
        req_addr = a; req_op = op; req_nowrite = nw; req_wdata = wd; req_valid = 1'b1;
        k = cyc + 1;
        tick();
        // Scramble the request bus: the captured copy must be used.
        req_valid   = 1'b0;
        req_addr    = 12'($urandom);
        req_op      = 2'($urandom_range(0, 3));
        req_nowrite = ($urandom_range(0, 1) == 1);
        req_wdata   = {$urandom, $urandom};
        check("ready_busy", req_ready, 1'b0);
        check("rsp_low_read", rsp_valid, 1'b0);
        tick();
        check("rsp_low_write", rsp_valid, 1'b0);
        tick();
        check("rsp_low_resp", rsp_valid, 1'b0);
        tick();
        rd = rsp_rdata;
        il = rsp_illegal;
        model_read(a, k, hit, old);
        attempt = (op == 2'b01) || (op[1] && !nw);
        exp_il  = !hit || (attempt && ((a[11:10] == 2'b11) || (a == 12'h301)));
        check("rsp_valid", rsp_valid, 1'b1);
        check($sformatf("illegal@%h", a), il, exp_il);
        check($sformatf("rdata@%h", a), rd, exp_il ? 64'h0 : old);
        if (!exp_il && op != 2'b00 && !nw) model_write(a, op, old, wd, k + 2);
    endtask

    logic [11:0] addr_tab [16] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'hB00, 12'hB02, 12'hF11, 12'hF12, 12'hF13, 12'hF14,
                                   12'h7C0, 12'h302, 12'hF15, 12'h000};

    initial begin
        logic [63:0] rd;
        logic        il;

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_op = '0;
        req_nowrite = 1'b0; req_wdata = '0; instret = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_illegal", rsp_illegal, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 64'h0);
        reset = 1'b0;
        model_reset();
        #1;
        check("ready_after_rst", req_ready, 1'b1);

        // mscratch write then read-back through a second RW
        access(12'h340, 2'b01, 1'b0, 64'hDEAD_BEEF, rd, il);
        access(12'h340, 2'b01, 1'b0, 64'h0, rd, il);
        check("dir_rw_old", rd, 64'hDEAD_BEEF);

        // set / clear sequence
        access(12'h340, 2'b01, 1'b0, 64'hF0, rd, il);
        access(12'h340, 2'b10, 1'b0, 64'h0F, rd, il);
        check("dir_rs_old", rd, 64'hF0);
        access(12'h340, 2'b11, 1'b0, 64'hF0, rd, il);
        check("dir_rc_old", rd, 64'hFF);
        access(12'h340, 2'b00, 1'b0, 64'h0, rd, il);
        check("dir_final", rd, 64'h0F);

        // read-only mhartid
        access(12'hF14, 2'b01, 1'b0, 64'h5, rd, il);
        check("dir_hart_wr_il", il, 1'b1);
        access(12'hF14, 2'b10, 1'b1, 64'h5, rd, il);
        check("dir_hart_rd", rd, 64'(HART));

        // mcycle wrap
        access(12'hB00, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, rd, il);
        access(12'hB00, 2'b00, 1'b0, 64'h0, rd, il);
        check("dir_mcycle_wrapped", rd < 64'd16, 1'b1);

        // mstatus WARL and unmapped address
        access(12'h300, 2'b01, 1'b0, '1, rd, il);
        access(12'h300, 2'b00, 1'b0, 64'h0, rd, il);
        check("dir_mstatus", rd, 64'h1888);
        access(12'h7C0, 2'b01, 1'b0, 64'h1, rd, il);
        check("dir_unmapped", il, 1'b1);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            access(addr_tab[$urandom_range(0, 15)], 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), {$urandom, $urandom}, rd, il);
        end

        // reset during WRITE aborts the access
        req_addr = 12'h340; req_op = 2'b01; req_nowrite = 1'b0;
        req_wdata = 64'h7; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("abort_ready", req_ready, 1'b0);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_rdata", rsp_rdata, 64'h0);
        tick();
        tick();
        check("abort_no_rsp", rsp_valid, 1'b0);
        reset = 1'b0;
        model_reset();
        #1;
        check("abort_ready_after", req_ready, 1'b1);
        access(12'h340, 2'b00, 1'b0, 64'h0, rd, il);
        check("abort_mscratch", rd, 64'h0);

        // a few more random accesses after the reset
        for (int i = 0; i < 20; i++) begin
            access(addr_tab[$urandom_range(0, 15)], 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), {$urandom, $urandom}, rd, il);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
